// File: rtl/mc_arb_pkg.sv
// Shared types and frame field layout for the array frame arbiter.
package mc_arb_pkg;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_FRM  = 2'd1,
    RD_FRM  = 2'd2,
    REFRESH = 2'd3
  } arb_state_t;

  // Requesting side of the array frame interface.
  typedef enum logic {
    SIDE_WR = 1'b0,
    SIDE_RD = 1'b1
  } side_t;

  // Bit positions inside an 89-bit array frame beat.
  localparam int RW_FLAG_BIT = 88;
  localparam int SOF_BIT     = 87;
  localparam int EOF_BIT     = 86;
  localparam int COL_MSB     = 85;
  localparam int COL_LSB     = 80;
  localparam int ROW_MSB     = 79;
  localparam int ROW_LSB     = 64;
  localparam int DATA_MSB    = 63;
  localparam int DATA_LSB    = 0;

  // Winner among the sides presenting a start-of-frame beat. The caller only
  // uses the result when at least one side is a candidate.
  //   rr_mode = 1 : alternate, the side served last loses a tie
  //   rr_mode = 0 : WR wins a tie unless RD has been starved to the limit
  function automatic side_t pick_side(input logic  wr_cand,
                                      input logic  rd_cand,
                                      input logic  rr_mode,
                                      input side_t last,
                                      input logic  starved);
    if (wr_cand && rd_cand) begin
      if (rr_mode) return (last == SIDE_RD) ? SIDE_WR : SIDE_RD;
      return starved ? SIDE_RD : SIDE_WR;
    end
    return rd_cand ? SIDE_RD : SIDE_WR;
  endfunction

endpackage

// File: rtl/mc_arb_starve_cnt.sv
// Saturating wait counter for the read side; at_limit forces RD to win the
// next fixed-priority arbitration.
module mc_arb_starve_cnt #(
  parameter int LIMIT = 64,
  parameter int WIDTH = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam logic [WIDTH-1:0] LIMIT_V = WIDTH'(LIMIT);

  logic [WIDTH-1:0] count;

  // Clear has priority; otherwise count up and hold at the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != LIMIT_V)) begin
      count <= count + 1'b1;
    end
  end

  assign at_limit = (count == LIMIT_V);

endmodule

// File: rtl/mc_frame_arbiter.sv
// Frame-level arbiter merging the write and read frame streams onto the
// single array frame interface, with refresh slotted in between frames.
//
// Handshake: every frame port is valid/ready. A beat transfers on a rising
// clk edge where vld and rdy are both high. The source holds vld and keeps
// data stable until that edge; rdy never depends on anything the source
// changes in response to rdy, and the arbiter never consumes a beat unless
// the array controller accepts it in the same cycle (zero-latency path).
module mc_frame_arbiter
  import mc_arb_pkg::*;
#(
  parameter int ARRAY_FRAME_DATA_WIDTH = 89,
  parameter int STARVE_LIMIT           = 64,
  parameter int STARVE_CNT_WIDTH       = 7
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              mc_en,
  input  logic                              arb_mode,
  input  logic                              wr_frame_vld,
  output logic                              wr_frame_rdy,
  input  logic [ARRAY_FRAME_DATA_WIDTH-1:0] wr_frame_data,
  input  logic                              rd_frame_vld,
  output logic                              rd_frame_rdy,
  input  logic [ARRAY_FRAME_DATA_WIDTH-1:0] rd_frame_data,
  output logic                              array_frame_vld,
  input  logic                              array_frame_rdy,
  output logic [ARRAY_FRAME_DATA_WIDTH-1:0] array_frame_data,
  input  logic                              refresh_req,
  output logic                              refresh_gnt,
  input  logic                              refresh_done,
  output logic                              arb_busy,
  output logic [1:0]                        state_dbg
);

  arb_state_t state, state_nxt;
  side_t      rr_last, rr_last_nxt;

  logic wr_cand, rd_cand;
  logic grant_rd;
  logic starve_inc, starve_clr, starve_at_limit;

  // Only a beat carrying sof may open a frame.
  assign wr_cand = wr_frame_vld & wr_frame_data[SOF_BIT];
  assign rd_cand = rd_frame_vld & rd_frame_data[SOF_BIT];

  // RD waits while it has a beat up and is not owning the array; the wait
  // resets once RD is granted or stops requesting.
  assign starve_inc = rd_frame_vld;
  assign starve_clr = ~rd_frame_vld | grant_rd | (state == RD_FRM);

  mc_arb_starve_cnt #(
    .LIMIT (STARVE_LIMIT),
    .WIDTH (STARVE_CNT_WIDTH)
  ) u_starve (
    .clk      (clk),
    .rst      (rst),
    .inc      (starve_inc),
    .clr      (starve_clr),
    .at_limit (starve_at_limit)
  );

  // State and round-robin history registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      rr_last <= SIDE_RD;
    end else begin
      state   <= state_nxt;
      rr_last <= rr_last_nxt;
    end
  end

  // Next-state decode and the zero-latency beat mux for the owning side.
  always_comb begin
    state_nxt        = state;
    rr_last_nxt      = rr_last;
    grant_rd         = 1'b0;
    array_frame_vld  = 1'b0;
    array_frame_data = '0;
    wr_frame_rdy     = 1'b0;
    rd_frame_rdy     = 1'b0;
    refresh_gnt      = 1'b0;
    case (state)
      IDLE: begin
        if (refresh_req) begin
          state_nxt = REFRESH;
        end else if (mc_en && (wr_cand || rd_cand)) begin
          if (pick_side(wr_cand, rd_cand, arb_mode, rr_last, starve_at_limit) == SIDE_RD) begin
            state_nxt = RD_FRM;
            grant_rd  = 1'b1;
          end else begin
            state_nxt = WR_FRM;
          end
        end
      end
      WR_FRM: begin
        array_frame_vld  = wr_frame_vld;
        array_frame_data = wr_frame_data;
        wr_frame_rdy     = array_frame_rdy;
        if (wr_frame_vld && array_frame_rdy && wr_frame_data[EOF_BIT]) begin
          state_nxt   = IDLE;
          rr_last_nxt = SIDE_WR;
        end
      end
      RD_FRM: begin
        array_frame_vld  = rd_frame_vld;
        array_frame_data = rd_frame_data;
        rd_frame_rdy     = array_frame_rdy;
        if (rd_frame_vld && array_frame_rdy && rd_frame_data[EOF_BIT]) begin
          state_nxt   = IDLE;
          rr_last_nxt = SIDE_RD;
        end
      end
      REFRESH: begin
        refresh_gnt = 1'b1;
        if (refresh_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign arb_busy  = (state != IDLE);
  assign state_dbg = state;

  // A side waiting in IDLE must be presenting the first beat of a frame;
  // a mid-frame beat here means the upstream splitter lost framing.
  a_wr_sof_first: assert property (@(posedge clk) disable iff (rst)
    (state == IDLE && wr_frame_vld) |-> wr_frame_data[SOF_BIT]);
  a_rd_sof_first: assert property (@(posedge clk) disable iff (rst)
    (state == IDLE && rd_frame_vld) |-> rd_frame_data[SOF_BIT]);

endmodule

// File: tb/tb_mc_frame_arbiter.sv
// Randomized scoreboard bench for mc_frame_arbiter.
module tb_mc_frame_arbiter;
  import mc_arb_pkg::*;

  localparam int W     = 89;
  localparam int LIMIT = 8;
  localparam int CW    = 4;
  localparam int CKW   = 96;
  localparam int TMO   = 400;

  localparam bit S_WR = 1'b0;
  localparam bit S_RD = 1'b1;

  localparam int O_IDLE = 0;
  localparam int O_WR   = 1;
  localparam int O_RD   = 2;
  localparam int O_REF  = 3;

  // ---------------- clock / reset / DUT ----------------
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         mc_en = 1'b0;
  logic         arb_mode = 1'b0;
  logic         wr_frame_vld = 1'b0;
  logic         wr_frame_rdy;
  logic [W-1:0] wr_frame_data = '0;
  logic         rd_frame_vld = 1'b0;
  logic         rd_frame_rdy;
  logic [W-1:0] rd_frame_data = '0;
  logic         array_frame_vld;
  logic         array_frame_rdy = 1'b1;
  logic [W-1:0] array_frame_data;
  logic         refresh_req = 1'b0;
  logic         refresh_gnt;
  logic         refresh_done = 1'b0;
  logic         arb_busy;
  logic [1:0]   state_dbg;

  always #5 clk = ~clk;

  mc_frame_arbiter #(
    .ARRAY_FRAME_DATA_WIDTH (W),
    .STARVE_LIMIT           (LIMIT),
    .STARVE_CNT_WIDTH       (CW)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .mc_en            (mc_en),
    .arb_mode         (arb_mode),
    .wr_frame_vld     (wr_frame_vld),
    .wr_frame_rdy     (wr_frame_rdy),
    .wr_frame_data    (wr_frame_data),
    .rd_frame_vld     (rd_frame_vld),
    .rd_frame_rdy     (rd_frame_rdy),
    .rd_frame_data    (rd_frame_data),
    .array_frame_vld  (array_frame_vld),
    .array_frame_rdy  (array_frame_rdy),
    .array_frame_data (array_frame_data),
    .refresh_req      (refresh_req),
    .refresh_gnt      (refresh_gnt),
    .refresh_done     (refresh_done),
    .arb_busy         (arb_busy),
    .state_dbg        (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_wr_q[$];
  logic [W-1:0] exp_rd_q[$];
  int n_check = 0;
  int n_pass  = 0;
  int wr_acc  = 0;
  int rd_acc  = 0;
  int rdy_mode = 0;   // 0 always ready, 1 toggle each cycle, 2 random
  bit wr_fin, rd_fin;

  // Reference model of who owns the array interface.
  int m_owner   = O_IDLE;
  bit m_last_rd = 1'b1;
  int m_wait    = 0;

  task automatic check(input string name, input logic [CKW-1:0] act, input logic [CKW-1:0] exp);
    n_check++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic fail_msg(input string name, input string why);
    n_check++;
    $display("FAIL %s: %s", name, why);
  endtask

  function automatic logic [W-1:0] make_beat(input bit side, input bit sof, input bit eof);
    logic [W-1:0] b;
    b = '0;
    b[RW_FLAG_BIT] = ~side;
    b[SOF_BIT] = sof;
    b[EOF_BIT] = eof;
    b[COL_MSB:COL_LSB]   = 6'($urandom);
    b[ROW_MSB:ROW_LSB]   = 16'($urandom);
    b[DATA_MSB:DATA_LSB] = {$urandom, $urandom};
    return b;
  endfunction

  // ---------------- array-side ready driver ----------------
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       array_frame_rdy = 1'b1;
      1:       array_frame_rdy = ~array_frame_rdy;
      default: array_frame_rdy = ($urandom_range(0, 3) != 0);
    endcase
  end

  // ---------------- driver tasks (called at posedge+1) ----------------
  task automatic send_frame(input bit side, input int len, input int gap);
    logic [W-1:0] beat;
    int waited;
    bit done_beat;
    bit aborted;
    aborted = 1'b0;
    for (int b = 0; b < len && !aborted; b++) begin
      beat = make_beat(side, b == 0, b == len - 1);
      if (side) begin
        rd_frame_vld = 1'b1; rd_frame_data = beat; exp_rd_q.push_back(beat);
      end else begin
        wr_frame_vld = 1'b1; wr_frame_data = beat; exp_wr_q.push_back(beat);
      end
      done_beat = 1'b0;
      waited = 0;
      while (!done_beat && !aborted) begin
        @(negedge clk);
        if (rst) begin
          aborted = 1'b1;
        end else begin
          done_beat = side ? rd_frame_rdy : wr_frame_rdy;
          waited++;
          if (!done_beat && waited > TMO) begin
            fail_msg(side ? "rd_beat_wait" : "wr_beat_wait", "no rdy within cycle budget");
            aborted = 1'b1;
          end
          @(posedge clk); #1;
        end
      end
    end
    if (side) rd_frame_vld = 1'b0; else wr_frame_vld = 1'b0;
    if (aborted) begin @(posedge clk); #1; end
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic wait_beats(input bit side, input int target);
    int t = 0;
    while ((side ? rd_acc : wr_acc) < target) begin
      @(negedge clk); #1;
      t++;
      if (t > TMO) begin
        fail_msg("beat_count", "accepted beat count did not reach target");
        break;
      end
    end
  endtask

  task automatic do_refresh(input int hold);
    int t = 0;
    refresh_req = 1'b1;
    while (1) begin
      @(negedge clk);
      if (refresh_gnt) break;
      t++;
      if (t > TMO) begin
        fail_msg("refresh_gnt_wait", "refresh_gnt never rose");
        break;
      end
    end
    repeat (hold) @(posedge clk);
    #1;
    refresh_done = 1'b1;
    refresh_req  = 1'b0;
    @(posedge clk); #1;
    refresh_done = 1'b0;
  endtask

  // ---------------- monitor + reference model ----------------
  always @(negedge clk) begin : monitor
    logic [4:0]   e_ctrl;
    logic [W-1:0] e_beat;
    logic wr_c, rd_c, take_rd;
    int old_owner;
    if (rst) begin
      m_owner   = O_IDLE;
      m_last_rd = 1'b1;
      m_wait    = 0;
    end else begin
      e_ctrl[4] = (m_owner == O_WR) ? wr_frame_vld : (m_owner == O_RD) ? rd_frame_vld : 1'b0;
      e_ctrl[3] = (m_owner == O_WR) && array_frame_rdy;
      e_ctrl[2] = (m_owner == O_RD) && array_frame_rdy;
      e_ctrl[1] = (m_owner == O_REF);
      e_ctrl[0] = (m_owner != O_IDLE);
      check("ctrl", CKW'({array_frame_vld, wr_frame_rdy, rd_frame_rdy, refresh_gnt, arb_busy}),
            CKW'(e_ctrl));

      if (m_owner == O_WR && wr_frame_vld && array_frame_rdy) begin
        wr_acc++;
        if (exp_wr_q.size() == 0) fail_msg("wr_beat", "beat transferred with none outstanding");
        else begin
          e_beat = exp_wr_q.pop_front();
          check("wr_beat", CKW'(array_frame_data), CKW'(e_beat));
        end
      end
      if (m_owner == O_RD && rd_frame_vld && array_frame_rdy) begin
        rd_acc++;
        if (exp_rd_q.size() == 0) fail_msg("rd_beat", "beat transferred with none outstanding");
        else begin
          e_beat = exp_rd_q.pop_front();
          check("rd_beat", CKW'(array_frame_data), CKW'(e_beat));
        end
      end

      // Advance the model to what the coming clock edge should produce.
      wr_c = wr_frame_vld && wr_frame_data[SOF_BIT];
      rd_c = rd_frame_vld && rd_frame_data[SOF_BIT];
      take_rd = 1'b0;
      old_owner = m_owner;
      case (old_owner)
        O_IDLE: begin
          if (refresh_req) m_owner = O_REF;
          else if (mc_en && (wr_c || rd_c)) begin
            if (wr_c && rd_c) take_rd = arb_mode ? ~m_last_rd : (m_wait >= LIMIT);
            else take_rd = rd_c;
            m_owner = take_rd ? O_RD : O_WR;
          end
        end
        O_WR: if (wr_frame_vld && array_frame_rdy && wr_frame_data[EOF_BIT]) begin
          m_owner = O_IDLE; m_last_rd = 1'b0;
        end
        O_RD: if (rd_frame_vld && array_frame_rdy && rd_frame_data[EOF_BIT]) begin
          m_owner = O_IDLE; m_last_rd = 1'b1;
        end
        default: if (refresh_done) m_owner = O_IDLE;
      endcase
      if (!rd_frame_vld || old_owner == O_RD || take_rd) m_wait = 0;
      else if (m_wait < LIMIT) m_wait++;
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #600000;
    $display("FAIL watchdog: still running at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus sequence ----------------
  initial begin
    int base;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out", CKW'({array_frame_vld, wr_frame_rdy, rd_frame_rdy, refresh_gnt, arb_busy,
                              array_frame_data}), CKW'(0));
    rst = 1'b0;
    mc_en = 1'b1;
    arb_mode = 1'b0;

    // Fixed priority: WR and RD frames arrive together, plus a stray refresh_done.
    fork
      send_frame(S_WR, 4, 0);
      send_frame(S_RD, 4, 0);
      begin
        repeat (2) @(posedge clk);
        #1 refresh_done = 1'b1;
        @(posedge clk);
        #1 refresh_done = 1'b0;
      end
    join

    // Round robin with single-beat frames on both sides.
    arb_mode = 1'b1;
    fork
      begin repeat (6) send_frame(S_WR, 1, 0); end
      begin repeat (6) send_frame(S_RD, 1, 0); end
    join

    // Starvation guard: WR streams, RD waits until forced through.
    arb_mode = 1'b0;
    fork
      begin repeat (6) send_frame(S_WR, 3, 0); end
      send_frame(S_RD, 2, 0);
    join

    // Refresh requested mid-frame with RD pending.
    base = wr_acc;
    fork
      send_frame(S_WR, 8, 0);
      begin repeat (2) @(posedge clk); #1; send_frame(S_RD, 3, 0); end
      begin wait_beats(S_WR, base + 2); @(posedge clk); #1; do_refresh(5); end
    join

    // Back-pressure toggling on a read frame.
    rdy_mode = 1;
    base = rd_acc;
    send_frame(S_RD, 4, 0);
    check("rd_beats_toggle", CKW'(rd_acc - base), CKW'(4));
    rdy_mode = 0;

    // mc_en falling mid-frame: frame finishes, pending RD waits for re-enable.
    base = wr_acc;
    fork
      send_frame(S_WR, 4, 0);
      send_frame(S_RD, 2, 0);
      begin
        wait_beats(S_WR, base + 1);
        @(posedge clk); #1 mc_en = 1'b0;
        repeat (8) @(posedge clk);
        #1 mc_en = 1'b1;
      end
    join

    // Asynchronous reset on the third beat of a write frame.
    base = wr_acc;
    fork
      send_frame(S_WR, 8, 0);
      begin
        wait_beats(S_WR, base + 2);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check("rst_out", CKW'({array_frame_vld, wr_frame_rdy, rd_frame_rdy, refresh_gnt, arb_busy,
                                array_frame_data}), CKW'(0));
      end
    join
    exp_wr_q.delete();
    exp_rd_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    send_frame(S_WR, 2, 0);

    // Disabled controller with frames pending stays idle.
    mc_en = 1'b0;
    fork
      send_frame(S_WR, 2, 0);
      send_frame(S_RD, 2, 0);
      begin
        repeat (10) @(negedge clk);
        check("disabled_idle", CKW'({arb_busy, array_frame_vld, wr_frame_rdy, rd_frame_rdy}), CKW'(0));
        @(posedge clk); #1 mc_en = 1'b1;
      end
    join

    // Random traffic in both modes with random back-pressure, refresh and enable drops.
    rdy_mode = 2;
    for (int r = 0; r < 2; r++) begin
      arb_mode = r[0];
      wr_fin = 1'b0;
      rd_fin = 1'b0;
      fork
        begin
          for (int i = 0; i < 20; i++) send_frame(S_WR, $urandom_range(1, 5), $urandom_range(0, 2));
          wr_fin = 1'b1;
        end
        begin
          for (int j = 0; j < 20; j++) send_frame(S_RD, $urandom_range(1, 5), $urandom_range(0, 2));
          rd_fin = 1'b1;
        end
        begin
          while (!(wr_fin && rd_fin)) begin
            repeat ($urandom_range(15, 40)) @(posedge clk);
            #1;
            case ($urandom_range(0, 3))
              0: do_refresh($urandom_range(1, 4));
              1: begin
                mc_en = 1'b0;
                repeat ($urandom_range(1, 6)) @(posedge clk);
                #1 mc_en = 1'b1;
              end
              default: ;
            endcase
          end
        end
      join
    end
    rdy_mode = 0;

    repeat (4) @(posedge clk);
    #1;
    check("wr_q_empty", CKW'(exp_wr_q.size()), CKW'(0));
    check("rd_q_empty", CKW'(exp_rd_q.size()), CKW'(0));
    $display("%0d/%0d checks passed", n_pass, n_check);
    $finish;
  end

endmodule
